// File: rtl/text_lcd_ctrl.sv
// text_lcd_ctrl: HD44780 8-bit write controller; power-up wait, init sequence,
// then endless refresh of line 1 as "HH:MM:SS.CC" from snapshotted digits.
module text_lcd_ctrl #(
  parameter int T_POWERUP = 750000,
  parameter int T_SETUP   = 2,
  parameter int T_PW      = 12,
  parameter int T_HOLD    = 2,
  parameter int T_EXEC    = 2000,
  parameter int T_CLEAR   = 80000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] hour_10,
  input  logic [7:0] hour_1,
  input  logic [7:0] min_10,
  input  logic [7:0] min_1,
  input  logic [7:0] sec_10,
  input  logic [7:0] sec_1,
  input  logic [7:0] cnt_10,
  input  logic [7:0] cnt_1,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_data,
  output logic       init_done,
  output logic       frame_done
);
  localparam int M0 = T_POWERUP > T_CLEAR ? T_POWERUP : T_CLEAR;
  localparam int M1 = M0 > T_EXEC ? M0 : T_EXEC;
  localparam int M2 = M1 > T_PW ? M1 : T_PW;
  localparam int M3 = M2 > T_SETUP ? M2 : T_SETUP;
  localparam int TMAX = M3 > T_HOLD ? M3 : T_HOLD;
  localparam int TW = $clog2(TMAX) + 1;
  // Timer counts down to zero, so each phase loads its length minus one.
  localparam logic [TW-1:0] L_PWR = TW'(T_POWERUP - 1);
  localparam logic [TW-1:0] L_SET = TW'(T_SETUP - 1);
  localparam logic [TW-1:0] L_PW  = TW'(T_PW - 1);
  localparam logic [TW-1:0] L_HLD = TW'(T_HOLD - 1);
  localparam logic [TW-1:0] L_EXE = TW'(T_EXEC - 1);
  localparam logic [TW-1:0] L_CLR = TW'(T_CLEAR - 1);

  typedef enum logic [1:0] {PWRUP, INIT, ADDR, CHAR} top_t;
  typedef enum logic [1:0] {SETUP, PULSE, HOLD, WAIT} ph_t;

  top_t st_q, st_d;
  ph_t ph_q, ph_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0][7:0] snap_q, snap_d;
  logic e_q, e_d, rs_q, rs_d, init_done_q, init_done_d, frame_done_q, frame_done_d;
  logic [7:0] data_q, data_d;

  function automatic logic [7:0] init_byte(input logic [3:0] i);
    return i == 4'd0 ? 8'h38 : i == 4'd1 ? 8'h0C : i == 4'd2 ? 8'h06 : 8'h01;
  endfunction

  function automatic logic [7:0] char_byte(input logic [3:0] i, input logic [7:0][7:0] s);
    logic [7:0] b;
    case (i)
      4'd0:    b = s[0];
      4'd1:    b = s[1];
      4'd3:    b = s[2];
      4'd4:    b = s[3];
      4'd6:    b = s[4];
      4'd7:    b = s[5];
      4'd9:    b = s[6];
      4'd10:   b = s[7];
      4'd8:    b = 8'h2E;
      default: b = 8'h3A;
    endcase
    return b == 8'h00 ? 8'h20 : b;
  endfunction

  always_comb begin
    st_d = st_q;
    ph_d = ph_q;
    tmr_d = tmr_q - 1'b1;
    idx_d = idx_q;
    snap_d = snap_q;
    e_d = e_q;
    rs_d = rs_q;
    data_d = data_q;
    init_done_d = init_done_q;
    frame_done_d = 1'b0;
    if (tmr_q == '0) begin
      if (st_q == PWRUP) begin
        st_d = INIT;
        ph_d = SETUP;
        tmr_d = L_SET;
        idx_d = '0;
        rs_d = 1'b0;
        data_d = 8'h38;
      end else begin
        case (ph_q)
          SETUP: begin
            ph_d = PULSE;
            tmr_d = L_PW;
            e_d = 1'b1;
          end
          PULSE: begin
            ph_d = HOLD;
            tmr_d = L_HLD;
            e_d = 1'b0;
          end
          HOLD: begin
            ph_d = WAIT;
            tmr_d = (st_q == INIT && idx_q == 4'd3) ? L_CLR : L_EXE;
          end
          default: begin
            ph_d = SETUP;
            tmr_d = L_SET;
            if ((st_q == INIT && idx_q == 4'd3) || (st_q == CHAR && idx_q == 4'd10)) begin
              // Entering ADDR: take a coherent copy of the digits for this frame.
              st_d = ADDR;
              idx_d = '0;
              rs_d = 1'b0;
              data_d = 8'h80;
              snap_d = {cnt_1, cnt_10, sec_1, sec_10, min_1, min_10, hour_1, hour_10};
              init_done_d = 1'b1;
              frame_done_d = st_q == CHAR;
            end else if (st_q == ADDR) begin
              st_d = CHAR;
              idx_d = '0;
              rs_d = 1'b1;
              data_d = char_byte(4'd0, snap_q);
            end else begin
              idx_d = idx_q + 4'd1;
              data_d = st_q == INIT ? init_byte(idx_q + 4'd1) : char_byte(idx_q + 4'd1, snap_q);
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q <= PWRUP;
      ph_q <= SETUP;
      tmr_q <= L_PWR;
      idx_q <= '0;
      snap_q <= '0;
      e_q <= 1'b0;
      rs_q <= 1'b0;
      data_q <= 8'h00;
      init_done_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      st_q <= st_d;
      ph_q <= ph_d;
      tmr_q <= tmr_d;
      idx_q <= idx_d;
      snap_q <= snap_d;
      e_q <= e_d;
      rs_q <= rs_d;
      data_q <= data_d;
      init_done_q <= init_done_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign lcd_e = e_q;
  assign lcd_rs = rs_q;
  assign lcd_rw = 1'b0;
  assign lcd_data = data_q;
  assign init_done = init_done_q;
  assign frame_done = frame_done_q;
endmodule
